// File: rtl/wb_gain_calc_pkg.sv
// Shared definitions for the auto-white-balance gain calculator:
// widths, unity gain, FSM state encoding and the quotient-to-gain helper.
package wb_gain_calc_pkg;

  localparam int WB_STATIS_WIDTH = 29;
  localparam int WB_GAIN_WIDTH   = 10;
  localparam int GAIN_FRAC_BITS  = 8;

  // One quotient bit per cycle, so each division takes DIV_N cycles.
  localparam int DIV_N = WB_STATIS_WIDTH + GAIN_FRAC_BITS;
  localparam int CNT_W = $clog2(DIV_N + 1);

  localparam logic [WB_GAIN_WIDTH-1:0] UNITY_GAIN = WB_GAIN_WIDTH'(1 << GAIN_FRAC_BITS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    DIV_R    = 3'd2,
    DIV_B    = 3'd3,
    UPDATE   = 3'd4
  } gain_state_e;

  // Zero divisor wins over saturation; otherwise clamp to the largest gain.
  function automatic logic [WB_GAIN_WIDTH-1:0] quot_to_gain(
    input logic [DIV_N-1:0] quot,
    input logic             zero
  );
    if (zero)
      return UNITY_GAIN;
    else if (quot[DIV_N-1:WB_GAIN_WIDTH] != '0)
      return '1;
    else
      return quot[WB_GAIN_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/wb_gain_calc_if.sv
// Statistics-in / gains-out bundle of the gain calculator.
// master = statistics source and gain consumer, slave = wb_gain_calc.
// There is no valid/ready handshake: the statistics are level inputs
// sampled one cycle after an accepted interrupt rise, and o_gain_valid is
// a one-cycle pulse that the consumer must take when it appears (it
// cannot stall the calculator).
interface wb_gain_calc_if;
  import wb_gain_calc_pkg::*;

  logic                       i_interrupt_pin;
  logic                       i_awb_en;
  logic [WB_STATIS_WIDTH-1:0] iv_wb_statis_r;
  logic [WB_STATIS_WIDTH-1:0] iv_wb_statis_g;
  logic [WB_STATIS_WIDTH-1:0] iv_wb_statis_b;
  logic [WB_GAIN_WIDTH-1:0]   ov_wb_gain_r;
  logic [WB_GAIN_WIDTH-1:0]   ov_wb_gain_b;
  logic                       o_gain_valid;
  logic                       o_busy;
  logic                       o_div_zero;
  gain_state_e                state_dbg;

  modport master (
    output i_interrupt_pin, i_awb_en, iv_wb_statis_r, iv_wb_statis_g, iv_wb_statis_b,
    input  ov_wb_gain_r, ov_wb_gain_b, o_gain_valid, o_busy, o_div_zero, state_dbg
  );

  modport slave (
    input  i_interrupt_pin, i_awb_en, iv_wb_statis_r, iv_wb_statis_g, iv_wb_statis_b,
    output ov_wb_gain_r, ov_wb_gain_b, o_gain_valid, o_busy, o_div_zero, state_dbg
  );

endinterface

// File: rtl/wb_gain_calc_div.sv
// Serial restoring divider, one quotient bit per cycle, MSB first.
// The first bit is produced in the start cycle from the dividend/divisor
// inputs, so a run occupies exactly DVD_W cycles; done pulses the cycle
// after the last bit, while quotient and divisor_zero still describe that run.
module wb_serial_div #(
  parameter int DVD_W = 37,
  parameter int DVS_W = 29
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic             divisor_zero
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem;
  logic [DVD_W-1:0] dvd_sh;
  logic [DVS_W-1:0] dvs_q;
  logic [CW-1:0]    cnt;
  logic             running;

  logic [DVS_W-1:0] rem_in;
  logic [DVD_W-1:0] dvd_in;
  logic [DVS_W-1:0] dvs_in;
  logic [DVS_W:0]   trial;
  logic [DVS_W-1:0] diff;
  logic             fits;

  // One restoring step; trial is the DVS_W+1 bit partial remainder. When it
  // fits, the true difference is below the divisor, so the low bits suffice.
  always_comb begin
    rem_in = start ? '0 : rem;
    dvd_in = start ? dividend : dvd_sh;
    dvs_in = start ? divisor : dvs_q;
    trial  = {rem_in, dvd_in[DVD_W-1]};
    fits   = (trial >= {1'b0, dvs_in});
    diff   = trial[DVS_W-1:0] - dvs_in;
  end

  // Load on start, then keep stepping until all DVD_W bits are produced.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem      <= '0;
      dvd_sh   <= '0;
      dvs_q    <= '0;
      quotient <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || running) begin
        rem    <= fits ? diff : trial[DVS_W-1:0];
        dvd_sh <= dvd_in << 1;
        dvs_q  <= dvs_in;
      end
      if (start) begin
        quotient <= {{(DVD_W-1){1'b0}}, fits};
        cnt      <= CW'(DVD_W - 1);
        running  <= 1'b1;
      end else if (running) begin
        quotient <= {quotient[DVD_W-2:0], fits};
        cnt      <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign divisor_zero = (dvs_q == '0);

endmodule

// File: rtl/wb_gain_calc.sv
// Auto-white-balance gain calculator: on an enabled interrupt rise, latches
// the R/G/B statistics and runs the shared divider twice (G/R, then G/B)
// to produce fixed-point gains, published with a one-cycle valid pulse.
module wb_gain_calc
  import wb_gain_calc_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  wb_gain_calc_if.slave  bus
);

  gain_state_e                state;
  logic [CNT_W-1:0]           cnt;
  logic                       pin_d;
  logic                       rise;
  logic [WB_STATIS_WIDTH-1:0] r_cap, g_cap, b_cap;
  logic                       div_start;
  logic                       div_done;
  logic [DIV_N-1:0]           quotient;
  logic                       div_zero;
  logic [WB_STATIS_WIDTH-1:0] divisor;
  logic [WB_GAIN_WIDTH-1:0]   gain_r_hold;
  logic                       zero_r_hold;
  logic [WB_GAIN_WIDTH-1:0]   gain_r_q, gain_b_q;
  logic                       valid_q, busy_q, dz_q;

  // Delayed copy of the interrupt pin for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) pin_d <= 1'b0;
    else       pin_d <= bus.i_interrupt_pin;
  end

  assign rise    = bus.i_interrupt_pin & ~pin_d;
  // The B run starts while the FSM already sits in DIV_B.
  assign divisor = (state == DIV_B) ? b_cap : r_cap;

  wb_serial_div #(
    .DVD_W (DIV_N),
    .DVS_W (WB_STATIS_WIDTH)
  ) u_div (
    .clk          (clk),
    .reset        (reset),
    .start        (div_start),
    .dividend     ({g_cap, GAIN_FRAC_BITS'(0)}),
    .divisor      (divisor),
    .done         (div_done),
    .quotient     (quotient),
    .divisor_zero (div_zero)
  );

  // Sequencer: capture, two divider runs of DIV_N cycles, then publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      div_start   <= 1'b0;
      r_cap       <= '0;
      g_cap       <= '0;
      b_cap       <= '0;
      gain_r_hold <= UNITY_GAIN;
      zero_r_hold <= 1'b0;
      gain_r_q    <= UNITY_GAIN;
      gain_b_q    <= UNITY_GAIN;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      div_start <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= (state == CAPTURE) || (state == DIV_R) || (state == DIV_B);
      case (state)
        IDLE: begin
          if (rise && bus.i_awb_en) state <= CAPTURE;
        end
        CAPTURE: begin
          r_cap     <= bus.iv_wb_statis_r;
          g_cap     <= bus.iv_wb_statis_g;
          b_cap     <= bus.iv_wb_statis_b;
          cnt       <= '0;
          div_start <= 1'b1;
          state     <= DIV_R;
        end
        DIV_R: begin
          if (cnt == CNT_W'(DIV_N - 1)) begin
            cnt       <= '0;
            div_start <= 1'b1;
            state     <= DIV_B;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV_B: begin
          // The red result is reported in the first DIV_B cycle.
          if (div_done) begin
            gain_r_hold <= quot_to_gain(quotient, div_zero);
            zero_r_hold <= div_zero;
          end
          if (cnt == CNT_W'(DIV_N - 1)) begin
            cnt   <= '0;
            state <= UPDATE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UPDATE: begin
          gain_r_q <= gain_r_hold;
          gain_b_q <= quot_to_gain(quotient, div_zero);
          dz_q     <= zero_r_hold | div_zero;
          valid_q  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ov_wb_gain_r = gain_r_q;
  assign bus.ov_wb_gain_b = gain_b_q;
  assign bus.o_gain_valid = valid_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_div_zero   = dz_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_wb_gain_calc.sv
// Bench for wb_gain_calc: directed cases plus a few random statistics,
// expected gains queued at trigger time and compared on o_gain_valid.
module tb_wb_gain_calc;
  import wb_gain_calc_pkg::*;

  localparam int LAT = 3 + 2 * (WB_STATIS_WIDTH + GAIN_FRAC_BITS);  // 77

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   valid_cnt = 0;
  int   busy_cnt = 0;

  logic [20:0] exp_q[$];   // {div_zero, gain_r, gain_b}
  int          tq[$];      // cycle of the rise for each expected result

  wb_gain_calc_if bus();

  wb_gain_calc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- check task ----
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---- reference model ----
  function automatic logic [9:0] model_gain(input longint unsigned g, input longint unsigned d);
    longint unsigned q;
    if (d == 0) return 10'd256;
    q = (g << 8) / d;
    if (q > 1023) return 10'd1023;
    return 10'(q);
  endfunction

  // ---- scoreboard monitor ----
  always @(negedge clk) begin
    logic [20:0] e;
    int t;
    if (bus.o_busy) busy_cnt++;
    if (bus.o_gain_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        t = tq.pop_front();
        chk("gain_r", bus.ov_wb_gain_r, e[19:10]);
        chk("gain_b", bus.ov_wb_gain_b, e[9:0]);
        chk("div_zero", bus.o_div_zero, e[20]);
        chk("latency", cyc, t + LAT);
      end
    end
  end

  // ---- driver tasks ----
  task automatic run_calc(input int r, input int g, input int b, input bit retrig);
    int t0, v0;
    logic [9:0] er, eb;
    @(negedge clk);
    bus.iv_wb_statis_r = WB_STATIS_WIDTH'(r);
    bus.iv_wb_statis_g = WB_STATIS_WIDTH'(g);
    bus.iv_wb_statis_b = WB_STATIS_WIDTH'(b);
    bus.i_interrupt_pin = 1'b1;
    t0 = cyc;
    v0 = valid_cnt;
    er = model_gain(longint'(g), longint'(r));
    eb = model_gain(longint'(g), longint'(b));
    exp_q.push_back({(r == 0) || (b == 0), er, eb});
    tq.push_back(t0);
    for (int k = 1; k <= LAT - 1; k++) begin
      @(negedge clk);
      if (k == 2) bus.i_interrupt_pin = 1'b0;
      if (retrig && k == 19) bus.i_interrupt_pin = 1'b1;
      if (retrig && k == 22) bus.i_interrupt_pin = 1'b0;
      if (k == 1) chk("busy_t1", bus.o_busy, 0);
      if (k == 2) chk("busy_t2", bus.o_busy, 1);
      if (k == LAT - 1) chk("busy_last", bus.o_busy, 1);
    end
    @(negedge clk);
    chk("busy_after", bus.o_busy, 0);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("valid_timeout", 0, 1);
      exp_q.delete();
      tq.delete();
    end
    repeat (3) @(negedge clk);
    chk("valid_pulses", valid_cnt - v0, 1);
    chk("hold_gain_r", bus.ov_wb_gain_r, er);
    chk("hold_gain_b", bus.ov_wb_gain_b, eb);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_gain_r"}, bus.ov_wb_gain_r, 256);
    chk({tag, "_gain_b"}, bus.ov_wb_gain_b, 256);
    chk({tag, "_valid"}, bus.o_gain_valid, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_dz"}, bus.o_div_zero, 0);
    chk({tag, "_state"}, bus.state_dbg, IDLE);
  endtask

  // ---- stimulus ----
  initial begin
    int b0, v0, r, g, b;
    bus.i_interrupt_pin = 1'b0;
    bus.i_awb_en        = 1'b1;
    bus.iv_wb_statis_r  = '0;
    bus.iv_wb_statis_g  = '0;
    bus.iv_wb_statis_b  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_state("reset");

    run_calc(1000, 1000, 2000, 1'b0);   // 256 / 128
    run_calc(100, 1000, 3000, 1'b0);    // saturate 1023 / 85
    run_calc(0, 500, 500, 1'b0);        // zero R: unity, div_zero
    run_calc(700, 0, 900, 1'b0);        // G=0: gain 0, clears div_zero
    run_calc(1000, 1000, 0, 1'b0);      // zero B only
    run_calc(400, 1200, 600, 1'b1);     // second rise while busy ignored

    // Enable low: rise must not start anything.
    @(negedge clk);
    bus.i_awb_en = 1'b0;
    bus.i_interrupt_pin = 1'b1;
    b0 = busy_cnt;
    v0 = valid_cnt;
    repeat (2) @(negedge clk);
    bus.i_interrupt_pin = 1'b0;
    repeat (100) @(negedge clk);
    chk("en_off_busy", busy_cnt - b0, 0);
    chk("en_off_valid", valid_cnt - v0, 0);
    bus.i_awb_en = 1'b1;

    run_calc(0, 300, 800, 1'b0);        // leave div_zero=1 and gain_b != 256

    // Reset mid-division: no result, outputs back to reset values.
    @(negedge clk);
    bus.iv_wb_statis_r = 29'd1000;
    bus.iv_wb_statis_g = 29'd2000;
    bus.iv_wb_statis_b = 29'd4000;
    bus.i_interrupt_pin = 1'b1;
    v0 = valid_cnt;
    repeat (2) @(negedge clk);
    bus.i_interrupt_pin = 1'b0;
    repeat (38) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("midreset_no_valid", valid_cnt - v0, 0);

    run_calc(1000, 2000, 4000, 1'b0);   // 512 / 128

    for (int i = 0; i < 4; i++) begin
      r = (i == 0) ? int'($urandom_range(1, 50)) : int'($urandom_range(1, 29'h1fffffff));
      g = int'($urandom_range(0, 29'h1fffffff));
      b = int'($urandom_range(g / 4 + 1, 29'h1fffffff));
      run_calc(r, g, b, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "global timeout");
  end

endmodule
